// File: rtl/zynq_aes_stream_arb.sv
// ----------------------------------------------------------------------------
// zynq_aes_stream_arb
//
// Packet-level round-robin arbiter that shares one zynq_aes AXI4-Stream core
// between two requesters. Whole request packets are forwarded to the core
// with no buffering. The owner of every granted packet is queued in a small
// order FIFO, so each core response packet is routed back to the requester
// that issued the matching request. The core answers in request order.
//
// Ports
//   aclk, aresetn         clock, asynchronous active-low reset
//   s0_axis_*, s1_axis_*  request streams from requester 0 / 1
//   aes_m_axis_*          request stream to the core (s00_axis)
//   aes_s_axis_*          response stream from the core (m00_axis)
//   m0_axis_*, m1_axis_*  response streams to requester 0 / 1
//   stat_pkts0/1          forwarded request packet count per requester
//   stat_busy             cycles spent forwarding (saturating)
//
// Optional feature: define ZYNQ_AES_ARB_STATS_EN to build the statistics
// counters. Without it the stat_* ports are tied to zero.
// ----------------------------------------------------------------------------
module zynq_aes_stream_arb #(
    parameter int DATA_W      = 32,
    parameter int ORDER_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,

    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,

    output logic [DATA_W-1:0] aes_m_axis_tdata,
    output logic              aes_m_axis_tvalid,
    output logic              aes_m_axis_tlast,
    input  logic              aes_m_axis_tready,

    input  logic [DATA_W-1:0] aes_s_axis_tdata,
    input  logic              aes_s_axis_tvalid,
    input  logic              aes_s_axis_tlast,
    output logic              aes_s_axis_tready,

    output logic [DATA_W-1:0] m0_axis_tdata,
    output logic              m0_axis_tvalid,
    output logic              m0_axis_tlast,
    input  logic              m0_axis_tready,

    output logic [DATA_W-1:0] m1_axis_tdata,
    output logic              m1_axis_tvalid,
    output logic              m1_axis_tlast,
    input  logic              m1_axis_tready,

    output logic [15:0]       stat_pkts0,
    output logic [15:0]       stat_pkts1,
    output logic [31:0]       stat_busy
);

    localparam int PTR_W = $clog2(ORDER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } state_t;

    state_t             state;
    logic               grant_id;
    logic               last_grant;

    logic               owner_mem [ORDER_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;

    logic               fifo_full;
    logic               fifo_empty;
    logic               head;
    logic               grant_vld;
    logic               grant_nxt;
    logic               req_done;
    logic               rsp_done;

    assign fifo_full  = (fifo_cnt == CNT_W'(ORDER_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = owner_mem[rd_ptr];

    // Arbitration: only in IDLE and only while an owner slot is free.
    // On contention the requester that did not win last time is chosen.
    always_comb begin
        grant_vld = 1'b0;
        grant_nxt = 1'b0;
        if (state == ST_IDLE && !fifo_full) begin
            if (s0_axis_tvalid && s1_axis_tvalid) begin
                grant_vld = 1'b1;
                grant_nxt = ~last_grant;
            end else if (s0_axis_tvalid) begin
                grant_vld = 1'b1;
                grant_nxt = 1'b0;
            end else if (s1_axis_tvalid) begin
                grant_vld = 1'b1;
                grant_nxt = 1'b1;
            end
        end
    end

    // Request path: straight pass-through of the granted stream while in FWD.
    always_comb begin
        aes_m_axis_tdata  = '0;
        aes_m_axis_tvalid = 1'b0;
        aes_m_axis_tlast  = 1'b0;
        s0_axis_tready    = 1'b0;
        s1_axis_tready    = 1'b0;
        if (state == ST_FWD) begin
            if (grant_id) begin
                aes_m_axis_tdata  = s1_axis_tdata;
                aes_m_axis_tvalid = s1_axis_tvalid;
                aes_m_axis_tlast  = s1_axis_tlast;
                s1_axis_tready    = aes_m_axis_tready;
            end else begin
                aes_m_axis_tdata  = s0_axis_tdata;
                aes_m_axis_tvalid = s0_axis_tvalid;
                aes_m_axis_tlast  = s0_axis_tlast;
                s0_axis_tready    = aes_m_axis_tready;
            end
        end
    end

    assign req_done = (state == ST_FWD) && aes_m_axis_tvalid &&
                      aes_m_axis_tready && aes_m_axis_tlast;

    // Response path: route to the owner at the FIFO head. With no pending
    // owner the core is held off, so a response can never be misrouted.
    always_comb begin
        m0_axis_tdata     = '0;
        m0_axis_tvalid    = 1'b0;
        m0_axis_tlast     = 1'b0;
        m1_axis_tdata     = '0;
        m1_axis_tvalid    = 1'b0;
        m1_axis_tlast     = 1'b0;
        aes_s_axis_tready = 1'b0;
        if (!fifo_empty) begin
            if (head) begin
                m1_axis_tdata     = aes_s_axis_tdata;
                m1_axis_tvalid    = aes_s_axis_tvalid;
                m1_axis_tlast     = aes_s_axis_tlast;
                aes_s_axis_tready = m1_axis_tready;
            end else begin
                m0_axis_tdata     = aes_s_axis_tdata;
                m0_axis_tvalid    = aes_s_axis_tvalid;
                m0_axis_tlast     = aes_s_axis_tlast;
                aes_s_axis_tready = m0_axis_tready;
            end
        end
    end

    assign rsp_done = aes_s_axis_tvalid && aes_s_axis_tready && aes_s_axis_tlast;

    // Request FSM. last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        grant_id   <= grant_nxt;
                        last_grant <= grant_nxt;
                        state      <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (req_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Owner FIFO control. The owner is pushed at grant time, so a response
    // that finishes before its request packet is already routable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (grant_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rsp_done) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({grant_vld, rsp_done})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Owner FIFO storage; validity is tracked by the pointers above.
    always_ff @(posedge aclk) begin
        if (grant_vld) begin
            owner_mem[wr_ptr] <= grant_nxt;
        end
    end

`ifdef ZYNQ_AES_ARB_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [15:0] pkts0_cnt;
    logic [15:0] pkts1_cnt;
    logic [31:0] busy_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkts0_cnt <= '0;
            pkts1_cnt <= '0;
            busy_cnt  <= '0;
        end else begin
            if (req_done && !grant_id) begin
                pkts0_cnt <= pkts0_cnt + 16'd1;
            end
            if (req_done && grant_id) begin
                pkts1_cnt <= pkts1_cnt + 16'd1;
            end
            if (state == ST_FWD) begin
                busy_cnt <= sat_inc32(busy_cnt);
            end
        end
    end

    assign stat_pkts0 = pkts0_cnt;
    assign stat_pkts1 = pkts1_cnt;
    assign stat_busy  = busy_cnt;
`else
    assign stat_pkts0 = '0;
    assign stat_pkts1 = '0;
    assign stat_busy  = '0;
`endif

endmodule

// File: doc/zynq_aes_stream_arb.md
Name: zynq_aes_stream_arb

Overview:
- Packet-level arbiter that shares one zynq_aes AXI4-Stream core between two requesters.
- Each requester sends complete request packets (command, key, IV, data words, terminated by tlast). The arbiter forwards whole packets to the core in round-robin order.
- It records which requester owns each forwarded request, so the core's responses return to the right requester in issue order.
- Sits between the DMA-side stream masters and the zynq_aes s00/m00 AXI-stream ports.

Parameters:
- DATA_W, 32, stream data width (one WORD_S word per beat).
- ORDER_DEPTH, 4, entries in the owner-order FIFO; a power of two, minimum 2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s0_axis_tdata/tvalid/tlast  in  DATA_W/1/1  requester 0 request stream.
- s0_axis_tready  out  1  requester 0 ready.
- s1_axis_tdata/tvalid/tlast  in  DATA_W/1/1  requester 1 request stream.
- s1_axis_tready  out  1  requester 1 ready.
- aes_m_axis_tdata/tvalid/tlast  out  DATA_W/1/1  to core s00_axis.
- aes_m_axis_tready  in  1  core s00_axis_tready.
- aes_s_axis_tdata/tvalid/tlast  in  DATA_W/1/1  from core m00_axis.
- aes_s_axis_tready  out  1  to core m00_axis_tready.
- m0_axis_tdata/tvalid/tlast  out  DATA_W/1/1  response to requester 0.
- m0_axis_tready  in  1  requester 0 response ready.
- m1_axis_tdata/tvalid/tlast  out  DATA_W/1/1  response to requester 1.
- m1_axis_tready  in  1  requester 1 response ready.
- stat_pkts0, stat_pkts1  out  16 each  forwarded request packet counts (optional feature).
- stat_busy  out  32  cycles spent in FWD (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; last_grant = 1, so requester 0 wins first; order FIFO empty.
  - All tready/tvalid outputs 0; stat counters 0.
  - Reset mid-packet drops in-flight packets and pending ownership; there is no recovery beyond reset.
- Request FSM, IDLE:
  - No grant while the order FIFO is full (registered count == ORDER_DEPTH).
  - Exactly one requester with tvalid=1: grant it.
  - Both with tvalid=1: grant the one != last_grant.
  - On grant: grant_id registered, last_grant updated, grant_id pushed to the order FIFO, state -> FWD.
  - The arbitration cycle is a bubble; all tready stay 0 in IDLE.
- Request FSM, FWD:
  - Combinational pass-through: aes_m_axis_* = s{grant_id}_axis_*; s{grant_id}_axis_tready = aes_m_axis_tready.
  - The non-granted s*_tready stays 0.
  - On a beat with tvalid & tready & tlast: state -> IDLE. Minimum inter-packet gap is 1 cycle.
- Response path:
  - Order FIFO empty: aes_s_axis_tready = 0; m0/m1 tvalid = 0.
  - Otherwise head = owner id. m{head}_axis_* = aes_s_axis_*; aes_s_axis_tready = m{head}_axis_tready; the other m*_tvalid = 0.
  - FIFO pops on a response beat with tvalid & tready & tlast.
- Order FIFO:
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Pointers wrap modulo ORDER_DEPTH.
  - A response may complete before its request packet finishes; the entry is pushed at grant, so routing is already known.
- Ordering: the core returns responses in request order; the arbiter relies on this. A response tlast with an empty FIFO is impossible, since tready is 0.
- No data buffering: latency request-to-core and core-to-response is 0 cycles (combinational). Grant latency is 1 cycle from tvalid in IDLE.

Optional Feature:
- Macro: ZYNQ_AES_ARB_STATS_EN.
- Defined:
  - stat_pkts{n} increments on each tlast handshake of a forwarded request from requester n, wrapping at 16 bits.
  - stat_busy increments every cycle state == FWD, saturating at 0xFFFFFFFF.
  - All three reset to 0.
- Undefined: the ports remain but are tied to 0 and no counter logic is synthesized.

Test Plan:
- Single requester: s0 sends 8-word packet, s1 idle -> packet reaches core unchanged after 1-cycle bubble; response of 4 words with tlast appears only on m0; FIFO empty afterwards.
- Contention: s0 and s1 both valid at the same cycle after reset -> s0 forwarded first, then s1; responses routed m0 then m1; stat_pkts0 = stat_pkts1 = 1 when ZYNQ_AES_ARB_STATS_EN is defined.
- Back-to-back fairness: both always valid, 6 packets each -> grant order 0,1,0,1,... with no requester granted twice in a row.
- Backpressure: core tready oscillating 6 high / 2 low, m1 tready low for 10 cycles -> no beat lost or duplicated; aes_s_axis_tready follows m1_axis_tready while head = 1.
- FIFO full: core response path stalled, s0 issues 5 short packets with ORDER_DEPTH = 4 -> 4 granted, 5th held (s0 tready = 0) until first response tlast pops the FIFO.
- Reset mid-packet: aresetn low during word 3 of an s1 packet -> all outputs 0 immediately; after release the next grant goes to s0.
